// File: rtl/logic_unit_serial_if.sv
// Operand/result handshake bundle for logic_unit_serial.
// The ZERO flag exists only when LOGIC_UNIT_ZERO_FLAG_EN is defined.
interface logic_unit_serial_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic [1:0]       select;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] result;
  logic             out_valid;
  logic             out_ready;
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
  logic             zero;
`endif

  modport master (
    output data1, data2, select, in_valid, out_ready,
    input  in_ready, result, out_valid
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    , input zero
`endif
  );

  modport slave (
    input  data1, data2, select, in_valid, out_ready,
    output in_ready, result, out_valid
`ifdef LOGIC_UNIT_ZERO_FLAG_EN
    , output zero
`endif
  );
endinterface

// File: rtl/logic_unit_serial.sv
// Multi-cycle bitwise AND/OR/XOR/NOR unit, SLICE bits per clock, LSB slice first.
// Optional registered ZERO flag when LOGIC_UNIT_ZERO_FLAG_EN is defined.
//
// state | meaning
// IDLE  | ready for operands; RESULT keeps last value
// RUN   | one slice per edge, completes on slice NSLICE-1
// HOLD  | RESULT valid, waiting for consumer
module logic_unit_serial #(
  parameter int WIDTH = 8,
  parameter int SLICE = 2
) (
  input logic                clk,
  input logic                rst_n,
  logic_unit_serial_if.slave bus
);
  localparam int NSLICE = WIDTH / SLICE;
  localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] KLAST = CW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [1:0]       op_sel;
  logic [CW-1:0]    k;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] result_q;
  logic [SLICE-1:0] a_s;
  logic [SLICE-1:0] b_s;
  logic [SLICE-1:0] r_s;
  logic             accept;
  logic             done;

  assign accept = (state == IDLE) && bus.in_valid;
  assign done   = (state == RUN) && (k == KLAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_nxt = RUN;
      RUN:     if (k == KLAST)    state_nxt = HOLD;
      HOLD:    if (bus.out_ready) state_nxt = IDLE;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == HOLD);
  end

  // Operands shift right each RUN edge so the current slice is always at bit 0;
  // the accumulator fills from the top, landing slice k at [k*SLICE +: SLICE].
  always_comb begin
    a_s = op_a[SLICE-1:0];
    b_s = op_b[SLICE-1:0];
    case (op_sel)
      2'b00:   r_s = a_s & b_s;
      2'b01:   r_s = a_s | b_s;
      2'b10:   r_s = a_s ^ b_s;
      default: r_s = ~(a_s | b_s);
    endcase
    acc_nxt = acc >> SLICE;
    acc_nxt[WIDTH-1 -: SLICE] = r_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a   <= '0;
      op_b   <= '0;
      op_sel <= 2'b00;
      k      <= '0;
      acc    <= '0;
    end else if (accept) begin
      op_a   <= bus.data1;
      op_b   <= bus.data2;
      op_sel <= bus.select;
      k      <= '0;
      acc    <= '0;
    end else if (state == RUN) begin
      op_a   <= op_a >> SLICE;
      op_b   <= op_b >> SLICE;
      k      <= k + 1'b1;
      acc    <= acc_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    result_q <= '0;
    else if (done) result_q <= acc_nxt;
  end

  assign bus.result = result_q;

`ifdef LOGIC_UNIT_ZERO_FLAG_EN
  logic zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    zero_q <= 1'b0;
    else if (done) zero_q <= (acc_nxt == '0);
  end

  assign bus.zero = zero_q;
`endif
endmodule

// File: doc/logic_unit_serial.md
Name: logic_unit_serial

Overview:
- Parametrised, multi-cycle bitwise logic unit for the ALU datapath.
- Processes two WIDTH-bit operands in SLICE-bit slices, LSB slice first, one slice per clock.
- Registers the full result and presents it with a valid/ready handshake.
- Replaces fixed 8-bit single-op gates where area matters more than latency.

Parameters:
WIDTH, 8, operand/result width in bits; must be a multiple of SLICE.
SLICE, 2, bits processed per clock; 1 <= SLICE <= WIDTH.
NSLICE, WIDTH/SLICE, derived slice count; not for override.

Ports:
CLK  input  1  clock; all state changes on rising edge.
RESET  input  1  asynchronous, active-low reset.
DATA1  input  WIDTH  operand A; sampled on accept.
DATA2  input  WIDTH  operand B; sampled on accept.
SELECT  input  2  operation, sampled on accept: 00 AND, 01 OR, 10 XOR, 11 NOR.
IN_VALID  input  1  operands and SELECT valid.
IN_READY  output  1  unit can accept; high only in IDLE.
RESULT  output  WIDTH  registered result.
OUT_VALID  output  1  RESULT holds a completed operation.
OUT_READY  input  1  consumer takes RESULT.

Behaviour:
- Reset (RESET low, asynchronous, any state):
  - State goes to IDLE.
  - RESULT = 0, OUT_VALID = 0, IN_READY = 1.
  - Slice counter, operand registers and accumulator cleared.
  - In-flight operation discarded; no output is produced for it.
- Reset release: first rising edge with RESET high is a normal IDLE cycle; accept is allowed on it.
- States:
  - IDLE: IN_READY = 1. On an edge with IN_VALID = 1 (accept), capture DATA1, DATA2 and SELECT, clear counter k = 0 and the accumulator, go to RUN.
  - RUN: IN_READY = 0. Each edge computes slice k, bits [k*SLICE +: SLICE], with the captured op, writes it into the accumulator, then k = k + 1.
    - On the edge computing k = NSLICE-1: load RESULT with the full accumulated value (including that slice), set OUT_VALID = 1, go to HOLD.
  - HOLD: IN_READY = 0; RESULT and OUT_VALID held stable. On an edge with OUT_READY = 1: OUT_VALID = 0, go to IDLE.
- Latency:
  - OUT_VALID rises exactly NSLICE edges after the accept edge (4 for defaults).
  - Minimum initiation interval is NSLICE + 2 cycles.
- RESULT changes only on the completion edge of RUN and on reset; it keeps its last value while in IDLE.
- OUT_READY is ignored outside HOLD. IN_VALID is ignored outside IDLE.
- Simultaneous events:
  - OUT_READY in HOLD and IN_VALID on the same edge: HOLD goes to IDLE only. The new request is accepted on the next edge, when IN_READY is 1.
- Operand changes on DATA1, DATA2 or SELECT after accept have no effect.
- Counter width: clog2(NSLICE) bits, minimum 1.
  - SLICE = WIDTH: RUN lasts one edge.
  - SLICE = 1: RUN lasts WIDTH edges.
- NOR is the bitwise inverse of OR over all WIDTH bits.

Optional Feature:
- Macro LOGIC_UNIT_ZERO_FLAG_EN.
- Defined:
  - Adds output port ZERO (1 bit).
  - ZERO is registered and loaded on the completion edge with (full result == 0).
  - ZERO is held through HOLD and IDLE, and cleared to 0 on reset.
- Not defined: no ZERO port and no flag logic; all other behaviour identical.

Test Plan:
1. Reset/idle: assert RESET low mid-RUN, 2 cycles into an OR of 0xF0,0x0F -> RESULT = 0x00, OUT_VALID = 0, IN_READY = 1 immediately; no OUT_VALID ever appears for that operation.
2. Basic ops, defaults: DATA1 = 0xA5, DATA2 = 0x3C, SELECT 00/01/10/11 -> RESULT 0x24 / 0xBD / 0x99 / 0x42, each with OUT_VALID rising exactly 4 edges after accept.
3. Backpressure: OUT_READY held 0 for 10 cycles after OR 0x81,0x18 -> RESULT = 0x99 stable and OUT_VALID = 1 throughout; IN_VALID pulses are ignored. OUT_READY = 1 -> OUT_VALID = 0 next edge.
4. Operand isolation: accept OR 0x01,0x02, then drive DATA1 = 0xFF during RUN -> RESULT = 0x03.
5. Parameter sweep: WIDTH = 16, SLICE = 1 and SLICE = 16; XOR of 0xFFFF,0x1234 -> RESULT = 0xEDCB with latency 16 and 1 respectively.
6. Zero flag (LOGIC_UNIT_ZERO_FLAG_EN defined): AND 0xF0,0x0F -> RESULT = 0x00, ZERO = 1; then OR 0xF0,0x0F -> RESULT = 0xFF, ZERO = 0.
